fir_mac_sequencer: RTL and testbench

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_mac_sequencer.sv | 144 ++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Sequential FIR filter: one shared signed multiplier and a wide accumulator
// walk all N taps per accepted sample, then hold the result until it is taken.
module fir_mac_sequencer #(
    parameter int N     = 50,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic                 coef_we,
    input  logic [$clog2(N)-1:0] coef_addr,
    input  logic [WIDTH-1:0]     coef_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 coef_err
);

    localparam int AW  = $clog2(N);
    localparam int AW1 = AW + 1;
    localparam int AccW = 2 * WIDTH;
    localparam logic [AW-1:0] N_LAST = AW'(N - 1);
    localparam logic [AW-1:0] N_MOD  = AW'(N);
    localparam logic [AW:0]   N_EXT  = AW1'(N);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            np_q, np_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic signed [AccW-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]         y_q, y_d;
    logic                     err_q, err_d;
    logic [WIDTH-1:0]         smp_q [N];
    logic [WIDTH-1:0]         coef_q [N];

    logic                     smp_we, smp_clr, coef_wr, addr_ok;
    logic [AW-1:0]            np_inc, rd_idx;
    logic [WIDTH-1:0]         smp_rd, coef_rd;
    logic signed [AccW-1:0]   smp_ext, coef_ext, prod, acc_nxt;

    assign addr_ok = ({1'b0, coef_addr} < N_EXT);
    assign np_inc  = (np_q == N_LAST) ? '0 : np_q + AW'(1);

    // (np - idx) mod N: the 2^AW wrap of the subtraction is undone by adding N mod 2^AW
    assign rd_idx  = (np_q - idx_q) + ((np_q < idx_q) ? N_MOD : '0);
    assign smp_rd  = smp_q[rd_idx];
    assign coef_rd = coef_q[idx_q];
    assign smp_ext  = {{WIDTH{smp_rd[WIDTH-1]}}, smp_rd};
    assign coef_ext = {{WIDTH{coef_rd[WIDTH-1]}}, coef_rd};
    assign prod     = smp_ext * coef_ext;
    assign acc_nxt  = acc_q + prod;

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;
    assign coef_err  = err_q;

    always_comb begin
        state_d = state_q;
        np_d    = np_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        y_d     = y_q;
        err_d   = 1'b0;
        smp_we  = 1'b0;
        smp_clr = 1'b0;
        coef_wr = 1'b0;
        case (state_q)
            IDLE: begin
                coef_wr = coef_we && addr_ok;
                err_d   = coef_we && !addr_ok;
                if (flush) begin
                    smp_clr = 1'b1;
                    np_d    = '0;
                end else if (in_valid) begin
                    np_d    = np_inc;
                    smp_we  = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                err_d = coef_we;
                acc_d = acc_nxt;
                if (idx_q == N_LAST) begin
                    idx_d   = '0;
                    y_d     = acc_nxt[WIDTH-1:0];
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            OUT: begin
                err_d = coef_we;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            np_q    <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            np_q    <= np_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) smp_q[i] <= '0;
        end else if (smp_clr) begin
            for (int i = 0; i < N; i++) smp_q[i] <= '0;
        end else if (smp_we) begin
            smp_q[np_d] <= x;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) coef_q[i] <= '0;
        end else if (coef_wr) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer (N=4, WIDTH=16): the driver queues
// hand-computed results, a negedge monitor checks them as y is presented.
module tb_fir_mac_sequencer;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk, reset, in_valid, in_ready, coef_we, flush;
    logic         out_valid, out_ready, busy, coef_err;
    logic [W-1:0] x, coef_data, y;
    logic [1:0]   coef_addr;

    typedef struct {
        logic [W-1:0] y;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic prev_vld = 1'b0;

    fir_mac_sequencer #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .busy(busy), .coef_err(coef_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle y is presented it must match the queue head
    initial forever begin
        @(negedge clk);
        if (reset && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got y=0x%0h, expected no output", y);
            end else begin
                if (!prev_vld) chk("latency", 32'(cyc - sb[0].cyc), N);
                chk("y", {16'h0, y}, {16'h0, sb[0].y});
                chk("in_ready_in_out", {31'h0, in_ready}, 0);
                if (out_ready) void'(sb.pop_front());
            end
        end
        prev_vld = out_valid;
    end

    task automatic send(input logic [W-1:0] v, input logic [W-1:0] e);
        int t = 0;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0, expected 1");
            return;
        end
        in_valid = 1'b1;
        x        = v;
        sb.push_back('{y: e, cyc: cyc + 1});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || sb.size() != 0) && t < 300) begin
            tick();
            t++;
        end
        if (busy || sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy=%0d pending=%0d, expected 0/0", busy, sb.size());
        end
    endtask

    task automatic wcoef(input logic [1:0] a, input logic [W-1:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        tick();
        coef_we = 1'b0;
        chk("coef_err_idle_write", {31'h0, coef_err}, 0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        #1;
        chk("in_ready_flush", {31'h0, in_ready}, 0);
        tick();
        flush = 1'b0;
    endtask

    initial begin
        int t;
        reset = 1'b0; in_valid = 1'b0; x = '0; coef_we = 1'b0; coef_addr = '0;
        coef_data = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_y", {16'h0, y}, 0);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_coef_err", {31'h0, coef_err}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_in_ready", {31'h0, in_ready}, 1);

        // impulse response
        wcoef(0, 1); wcoef(1, 2); wcoef(2, 3); wcoef(3, 4);
        send(1, 1); send(0, 2); send(0, 3); send(0, 4); send(0, 0);
        wait_idle();

        // running sums through the pointer wrap
        for (int i = 0; i < N; i++) wcoef(2'(i), 1);
        send(100, 100); send(200, 300); send(300, 600); send(400, 1000); send(500, 1400);
        wait_idle();

        // coefficient write while busy is rejected; old coef[0] stays in use
        send(10, 1210);
        coef_we = 1'b1; coef_addr = 0; coef_data = 7;
        tick();
        coef_we = 1'b0;
        chk("coef_err_pulse", {31'h0, coef_err}, 1);
        tick();
        chk("coef_err_clear", {31'h0, coef_err}, 0);
        send(20, 930);
        wait_idle();

        // output stall: y held, in_ready low, release returns to IDLE in one cycle
        do_flush();
        out_ready = 1'b0;
        send(7, 7);
        t = 0;
        while (!out_valid && t < 50) begin
            tick();
            t++;
        end
        chk("stall_reached_out", {31'h0, out_valid}, 1);
        repeat (5) tick();
        out_ready = 1'b1;
        tick();
        chk("stall_release_in_ready", {31'h0, in_ready}, 1);
        chk("stall_release_out_valid", {31'h0, out_valid}, 0);
        wait_idle();

        // accumulator wraps, y is the truncated low half
        do_flush();
        for (int i = 0; i < N; i++) wcoef(2'(i), 16'h7FFF);
        send(16'h7FFF, 16'h0001); send(16'h7FFF, 16'h0002); send(16'h7FFF, 16'h0003);
        send(16'h7FFF, 16'h0004); send(16'h7FFF, 16'h0004);
        wait_idle();

        // reset in the middle of a MAC pass
        send(9, 0);
        tick(); tick();
        sb.delete();
        #2 reset = 1'b0;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 0);
        chk("midrst_busy", {31'h0, busy}, 0);
        tick();
        reset = 1'b1;
        repeat (8) tick();
        chk("midrst_y", {16'h0, y}, 0);
        do_flush();
        wcoef(0, 1);
        send(5, 5);
        wait_idle();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
